cmd_pack_split: RTL and testbench
=================================

// Module: cmd_pack_split
// PURPOSE
//  Upstream stage of the BPI command path, feeding cmd_send. Buffers one command burst,
//  splits it into at most MAX_PACK packets of <=PAYLOAD_MAX bytes each, and emits every
//  packet as a contiguous frame: pack_num, pack_idx, length, then payload.
//  Issues the next packet only after the downstream read_continue pulse.
// PARAMETERS
//  DEPTH        1024  command buffer depth in bytes (power of 2)
//  PAYLOAD_MAX  200   max payload bytes per packet (1..255)
//  MAX_PACK     6     max packets per command (downstream accepts 1..6)
//  TIMEOUT      65535 cycles to wait for read_continue (CMD_TIMEOUT_EN only)
// PORTS
//  clk            in  1  system clock
//  rst            in  1  asynchronous, active-low reset
//  cmd_din        in  8  command byte
//  cmd_din_en     in  1  high for the whole contiguous command burst
//  read_continue  in  1  1-cycle pulse from cmd_send: packet consumed
//  con_dout       out 8  frame byte to cmd_send
//  con_dout_en    out 1  high for exactly 3+length cycles per frame
//  busy           out 1  high from end of accepted burst until final read_continue
//  err_drop       out 1  1-cycle pulse: command discarded
//  err_timeout    out 1  1-cycle pulse: continue wait expired (0 when macro absent)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, write pointer and counters 0. Mid-operation reset
//  aborts the command; no partial frame is completed after reset deasserts.
//  IDLE->LOAD on cmd_din_en. In LOAD, each byte is written to the buffer at wr_ptr++.
//  Burst end is the falling edge of cmd_din_en. Then the FSM enters CALC, L = byte count.
//  CALC: pack_num = ceil(L/PAYLOAD_MAX). Drop (err_drop=1, ->IDLE) if L==0, L>DEPTH
//   (wr_ptr saturates, excess ignored), or pack_num>MAX_PACK. Else busy=1, idx=1 ->HDR0.
//  Per-packet length = PAYLOAD_MAX, except the last packet carries L-(pack_num-1)*PAYLOAD_MAX.
//  This value is never 0.
//  HDR0 outputs pack_num; HDR1 outputs idx; HDR2 outputs length and issues the 1st RAM read.
//  PAYLOAD: one byte per cycle, RAM read 1-cycle latency. After the last byte ->WAIT_CONT.
//  First header byte appears 2 cycles after cmd_din_en falls. Frames are gap-free.
//  con_dout=0 whenever con_dout_en=0. Each frame is followed by at least 1 idle cycle.
//  WAIT_CONT: on read_continue, if idx<pack_num then idx++ and ->HDR0. Otherwise busy=0
//   and ->IDLE. read_continue outside WAIT_CONT is ignored.
//  cmd_din_en while busy: bytes ignored, err_drop pulses once on that burst's falling edge.
//  If cmd_din_en is asserted in the same cycle the FSM returns to IDLE, the burst is
//  accepted, starting at that cycle.
//  Byte counter is 11 bits and saturates at DEPTH. Arithmetic is unsigned.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_CONT.
//   When it reaches TIMEOUT: err_timeout pulses, busy=0, state ->IDLE, command abandoned.
//  CMD_TIMEOUT_EN undefined: WAIT_CONT waits indefinitely; err_timeout is tied to 0.
// STRUCTURE
//  Package cmd_split_pkg: FSM state encodings (IDLE,LOAD,CALC,HDR0,HDR1,HDR2,PAYLOAD,
//   WAIT_CONT), header byte offsets, MAX_PACK default.
//  Sub-module cmd_split_buf: simple dual-port RAM, DEPTH x 8, registered read.
//  FSM, counters and header mux live in cmd_pack_split.
// TESTING
//  1) 10-byte burst 0x01..0x0A, PAYLOAD_MAX=200 -> frame 01 01 0A 01..0A (13 cycles),
//     first byte 2 cycles after burst end. read_continue -> busy falls, no further frame.
//  2) 450-byte burst, PAYLOAD_MAX=200 -> frames (03,01,C8), (03,02,C8), (03,03,32).
//     Each frame is held until read_continue. Payload order matches input.
//  3) 1201-byte burst (pack_num 7) -> err_drop pulse, no frame, busy stays 0.
//     0-length (1-cycle-low) case -> no frame.
//  4) New 5-byte burst during WAIT_CONT of (2) -> ignored, err_drop pulse, frames of (2)
//     unaffected. Stray read_continue while IDLE -> no effect.
//  5) Assert rst mid-PAYLOAD of frame 2 -> outputs 0 immediately. Next 4-byte burst
//     -> clean 01 01 04 frame.
//  6) CMD_TIMEOUT_EN, TIMEOUT=100, no read_continue -> err_timeout pulse 100 cycles
//     into WAIT_CONT, busy=0. Without macro -> waits >1000 cycles, no error.

Source files
------------

// File: rtl/cmd_split_pkg.sv
// Shared types for the command pack/split path: FSM states, header byte offsets, defaults.
package cmd_split_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StHdr0,
    StHdr1,
    StHdr2,
    StPayload,
    StWaitCont
  } state_t;

  typedef enum logic [1:0] {
    HdrPackNum = 2'd0,
    HdrIdx     = 2'd1,
    HdrLen     = 2'd2
  } hdr_ofs_t;

  localparam int unsigned MAX_PACK_DEF = 6;

  function automatic logic [7:0] hdr_byte(hdr_ofs_t ofs, logic [7:0] pack_num,
                                          logic [7:0] idx, logic [7:0] len);
    hdr_byte = '0;
    case (ofs)
      HdrPackNum: hdr_byte = pack_num;
      HdrIdx:     hdr_byte = idx;
      HdrLen:     hdr_byte = len;
      default:    hdr_byte = '0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_split_buf.sv
// Command burst buffer: simple dual-port RAM, DEPTH x 8, one-cycle registered read.
module cmd_split_buf #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/cmd_pack_split.sv
// Buffers one command burst and re-emits it as <=MAX_PACK framed packets, paced by read_continue.
// Optional continue-wait timeout is enabled by defining CMD_TIMEOUT_EN.
module cmd_pack_split
  import cmd_split_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned PAYLOAD_MAX = 200,
  parameter int unsigned MAX_PACK    = MAX_PACK_DEF,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_cmd_din,
  input  logic       i_cmd_din_en,
  input  logic       i_read_continue,
  output logic [7:0] o_con_dout,
  output logic       o_con_dout_en,
  output logic       o_busy,
  output logic       o_err_drop,
  output logic       o_err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_ign, r_err_drop;
  logic [AW-1:0] r_rd_ptr;
  logic [7:0]    r_pack_num, r_idx, r_last_len, r_byte_cnt;
  logic          w_start, w_we, w_drop_calc, w_drop_ign, w_last_byte, w_last_pack, w_to_hit;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_rdata, w_len;
  logic [CW:0]   w_pack_num_full;

  // A burst seen while not idle is tracked in r_ign until it ends, so its tail is never taken
  // as the start of a new command.
  assign w_start     = (r_state == StIdle) && i_cmd_din_en && !r_ign;
  assign w_we        = w_start || ((r_state == StLoad) && i_cmd_din_en && (r_cnt < CW'(DEPTH)));
  assign w_waddr     = w_start ? '0 : r_cnt[AW-1:0];
  assign w_drop_ign  = r_ign && !i_cmd_din_en;

  assign w_pack_num_full = ({1'b0, r_cnt} + (CW+1)'(PAYLOAD_MAX - 1)) / (CW+1)'(PAYLOAD_MAX);
  assign w_drop_calc = (r_cnt == '0) || r_ovf || (w_pack_num_full > (CW+1)'(MAX_PACK));
  assign w_len       = (r_idx == r_pack_num) ? r_last_len : 8'(PAYLOAD_MAX);
  assign w_last_byte = (r_byte_cnt == w_len - 8'd1);
  assign w_last_pack = (r_idx >= r_pack_num);

  cmd_split_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_cmd_din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

`ifdef CMD_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_err_timeout;

  assign w_to_hit = (r_state == StWaitCont) && !i_read_continue &&
                    (r_to_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_to_cnt      <= (r_state == StWaitCont) ? r_to_cnt + 16'd1 : '0;
      r_err_timeout <= w_to_hit;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_to_hit      = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:     if (w_start) w_state_nxt = StLoad;
      StLoad:     if (!i_cmd_din_en) w_state_nxt = StCalc;
      StCalc:     w_state_nxt = w_drop_calc ? StIdle : StHdr0;
      StHdr0:     w_state_nxt = StHdr1;
      StHdr1:     w_state_nxt = StHdr2;
      StHdr2:     w_state_nxt = StPayload;
      StPayload:  if (w_last_byte) w_state_nxt = StWaitCont;
      StWaitCont: begin
        if (i_read_continue) begin
          w_state_nxt = w_last_pack ? StIdle : StHdr0;
        end else if (w_to_hit) begin
          w_state_nxt = StIdle;
        end
      end
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_ign      <= 1'b0;
      r_err_drop <= 1'b0;
      r_rd_ptr   <= '0;
      r_pack_num <= '0;
      r_idx      <= '0;
      r_last_len <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_err_drop <= ((r_state == StCalc) && w_drop_calc) || w_drop_ign;
      r_ign      <= i_cmd_din_en && (r_ign || !((r_state == StIdle) || (r_state == StLoad)));
      case (r_state)
        StIdle: begin
          r_ovf <= 1'b0;
          r_cnt <= w_start ? CW'(1) : '0;
        end
        StLoad: begin
          if (i_cmd_din_en) begin
            if (r_cnt == CW'(DEPTH)) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        StCalc: begin
          r_pack_num <= 8'(w_pack_num_full);
          r_last_len <= 8'({1'b0, r_cnt} -
                           (w_pack_num_full - (CW+1)'(1)) * (CW+1)'(PAYLOAD_MAX));
          r_idx      <= 8'd1;
          r_rd_ptr   <= '0;
        end
        StHdr2: begin
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          r_byte_cnt <= '0;
        end
        StPayload: begin
          if (!w_last_byte) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_byte_cnt <= r_byte_cnt + 8'd1;
          end
        end
        StWaitCont: begin
          if (i_read_continue && !w_last_pack) r_idx <= r_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_con_dout    = '0;
    o_con_dout_en = 1'b0;
    case (r_state)
      StHdr0: begin
        o_con_dout_en = 1'b1;
        o_con_dout    = hdr_byte(HdrPackNum, r_pack_num, r_idx, w_len);
      end
      StHdr1: begin
        o_con_dout_en = 1'b1;
        o_con_dout    = hdr_byte(HdrIdx, r_pack_num, r_idx, w_len);
      end
      StHdr2: begin
        o_con_dout_en = 1'b1;
        o_con_dout    = hdr_byte(HdrLen, r_pack_num, r_idx, w_len);
      end
      StPayload: begin
        o_con_dout_en = 1'b1;
        o_con_dout    = w_rdata;
      end
      default: ;
    endcase
  end

  assign o_busy     = ((r_state == StCalc) && !w_drop_calc) || (r_state == StHdr0) ||
                      (r_state == StHdr1) || (r_state == StHdr2) ||
                      (r_state == StPayload) || (r_state == StWaitCont);
  assign o_err_drop = r_err_drop;

endmodule

// File: tb/tb_cmd_pack_split.sv
// Scoreboard bench for cmd_pack_split: expected frame bytes queued at stimulus, checked on output.
module tb_cmd_pack_split;

  localparam int PM = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_din = '0;
  logic       cmd_din_en = 1'b0;
  logic       read_continue = 1'b0;
  logic [7:0] con_dout;
  logic       con_dout_en, busy, err_drop, err_timeout;

  always #5 clk = ~clk;

  cmd_pack_split #(
    .DEPTH       (1024),
    .PAYLOAD_MAX (PM),
    .MAX_PACK    (6),
    .TIMEOUT     (100)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cmd_din       (cmd_din),
    .i_cmd_din_en    (cmd_din_en),
    .i_read_continue (read_continue),
    .o_con_dout      (con_dout),
    .o_con_dout_en   (con_dout_en),
    .o_busy          (busy),
    .o_err_drop      (err_drop),
    .o_err_timeout   (err_timeout)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_drop = 0;
  int         n_to = 0;
  int         run = 0;
  logic [7:0] q_exp [$];
  int         q_len [$];
  logic [7:0] data [0:1299];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Output monitor: pops the scoreboard per byte and checks frame lengths at frame end.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (con_dout_en) begin
        if (q_exp.size() == 0) chk("extra_byte", 32'(con_dout_en), 32'd0);
        else chk("frame_byte", 32'(con_dout), 32'(q_exp.pop_front()));
        run++;
      end else begin
        if (run != 0) begin
          if (q_len.size() == 0) chk("extra_frame", run, 0);
          else chk("frame_len", run, q_len.pop_front());
          run = 0;
        end
        chk("idle_zero", 32'(con_dout), 32'd0);
      end
      if (err_drop) n_drop++;
      if (err_timeout) n_to++;
    end
  end

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) data[i] = 8'($urandom);
  endtask

  task automatic send_burst(input int n, input bit junk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_din    = junk ? 8'($urandom) : data[i];
      cmd_din_en = 1'b1;
    end
    @(posedge clk); #1;
    cmd_din_en = 1'b0;
    cmd_din    = '0;
  endtask

  task automatic push_frame(input int l, input int idx);
    int pn, plen, base;
    pn   = (l + PM - 1) / PM;
    plen = (idx < pn) ? PM : l - (pn - 1) * PM;
    base = (idx - 1) * PM;
    q_exp.push_back(8'(pn));
    q_exp.push_back(8'(idx));
    q_exp.push_back(8'(plen));
    for (int j = 0; j < plen; j++) q_exp.push_back(data[base + j]);
    q_len.push_back(3 + plen);
  endtask

  task automatic wait_out(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!((q_exp.size() == 0) && !con_dout_en) && (c < 400));
    if (c >= 400) chk(tag, 32'(q_exp.size()), 32'd0);
  endtask

  task automatic pulse_cont();
    @(posedge clk); #1;
    read_continue = 1'b1;
    @(posedge clk); #1;
    read_continue = 1'b0;
  endtask

  task automatic run_cmd(input int n);
    int pn;
    fill_rand(n);
    send_burst(n, 1'b0);
    pn = (n + PM - 1) / PM;
    for (int k = 1; k <= pn; k++) begin
      push_frame(n, k);
      if (k > 1) pulse_cont();
      wait_out("run_frame_wait");
      chk("run_busy_hold", 32'(busy), 32'd1);
    end
    pulse_cont();
    @(negedge clk);
    chk("run_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, c;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_en", 32'(con_dout_en), 32'd0);
    chk("rst_dout", 32'(con_dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(err_drop), 32'd0);
    chk("rst_timeout", 32'(err_timeout), 32'd0);

    // 1) 10 bytes 01..0A -> one 13-byte frame, first byte 2 cycles after burst end
    for (int i = 0; i < 10; i++) data[i] = 8'(i + 1);
    send_burst(10, 1'b0);
    q_exp.push_back(8'h01);
    q_exp.push_back(8'h01);
    q_exp.push_back(8'h0A);
    for (int i = 1; i <= 10; i++) q_exp.push_back(8'(i));
    q_len.push_back(13);
    @(negedge clk);
    chk("lat_cycle0", 32'(con_dout_en), 32'd0);
    @(negedge clk);
    chk("lat_cycle1", 32'(con_dout_en), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(con_dout_en), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_out("t1_wait");
    chk("t1_busy_wait", 32'(busy), 32'd1);
    pulse_cont();
    @(negedge clk);
    chk("t1_busy_end", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);

    // 2)+4) 450 bytes -> 3 frames; junk burst during wait is dropped
    fill_rand(450);
    send_burst(450, 1'b0);
    push_frame(450, 1);
    wait_out("t2_f1");
    repeat (20) @(negedge clk);
    chk("t2_hold1", 32'(busy), 32'd1);
    push_frame(450, 2);
    pulse_cont();
    wait_out("t2_f2");
    d0 = n_drop;
    send_burst(5, 1'b1);
    repeat (4) @(negedge clk);
    chk("t4_drop_busy", 32'(n_drop - d0), 32'd1);
    chk("t4_still_busy", 32'(busy), 32'd1);
    push_frame(450, 3);
    pulse_cont();
    wait_out("t2_f3");
    pulse_cont();
    @(negedge clk);
    chk("t2_busy_end", 32'(busy), 32'd0);
    pulse_cont();
    repeat (10) @(negedge clk);
    chk("t4_stray_cont", 32'(busy), 32'd0);

    // 3) Oversize commands drop; no burst at all produces nothing
    d0 = n_drop;
    send_burst(1201, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("t3_busy_1201", 32'(busy), 32'd0);
    end
    chk("t3_drop_1201", 32'(n_drop - d0), 32'd1);
    d0 = n_drop;
    send_burst(1025, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_drop_1025", 32'(n_drop - d0), 32'd1);
    d0 = n_drop;
    send_burst(0, 1'b1);
    repeat (10) @(negedge clk);
    chk("t3_zero_drop", 32'(n_drop - d0), 32'd0);
    chk("t3_zero_busy", 32'(busy), 32'd0);

    // Boundaries: exact packet size, one over, full buffer (6 packets)
    d0 = n_drop;
    run_cmd(200);
    run_cmd(201);
    run_cmd(1024);
    chk("bound_no_drop", 32'(n_drop - d0), 32'd0);

    // 5) Reset in the middle of frame 2's payload
    fill_rand(450);
    send_burst(450, 1'b0);
    push_frame(450, 1);
    wait_out("t5_f1");
    push_frame(450, 2);
    pulse_cont();
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    q_exp.delete();
    q_len.delete();
    #1;
    chk("t5_rst_en", 32'(con_dout_en), 32'd0);
    chk("t5_rst_dout", 32'(con_dout), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_after_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) data[i] = 8'(i + 1);
    send_burst(4, 1'b0);
    push_frame(4, 1);
    wait_out("t5_new");

    // 6) Continue wait timeout
`ifdef CMD_TIMEOUT_EN
    c = 0;
    while (!err_timeout && (c < 200)) begin
      @(negedge clk);
      c++;
    end
    chk("t6_timeout_cycle", c, 100);
    chk("t6_timeout_busy", 32'(busy), 32'd0);
`else
    c = 0;
    repeat (1100) @(negedge clk);
    chk("t6_no_timeout", n_to, c);
    chk("t6_still_busy", 32'(busy), 32'd1);
    pulse_cont();
    @(negedge clk);
    chk("t6_busy_end", 32'(busy), 32'd0);
`endif
    repeat (10) @(negedge clk);
    chk("final_queue", 32'(q_exp.size()), 32'd0);
    chk("final_len_queue", 32'(q_len.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
